// File: rtl/calc_op_sequencer_if.sv
// Request / calculator / response bundle for calc_op_sequencer.
// slave = sequencer side, master = requester + calculator side.
interface calc_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [1:0]  req_op;
  logic [7:0]  calc_a;
  logic [7:0]  calc_b;
  logic [1:0]  calc_op;
  logic        calc_start;
  logic [15:0] calc_result;
  logic        calc_done;
  logic        calc_div_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_div_zero;
  logic        rsp_timeout;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  calc_result, calc_done, calc_div_zero,
    input  rsp_ready,
    output req_ready,
    output calc_a, calc_b, calc_op, calc_start,
    output rsp_valid, rsp_result, rsp_op,
    output rsp_div_zero, rsp_timeout
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output calc_result, calc_done, calc_div_zero,
    output rsp_ready,
    input  req_ready,
    input  calc_a, calc_b, calc_op, calc_start,
    input  rsp_valid, rsp_result, rsp_op,
    input  rsp_div_zero, rsp_timeout
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// One-at-a-time command sequencer for the 8-bit calculator.
// Define CALC_SEQ_TIMEOUT_EN to enable the WAIT-state watchdog.
module calc_op_sequencer #(
  parameter int unsigned DIV_SETTLE     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  calc_op_sequencer_if.slave   bus,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        req_ready_q;
  logic        busy_q;
  logic [7:0]  calc_a_q;
  logic [7:0]  calc_b_q;
  logic [1:0]  calc_op_q;
  logic        calc_start_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_result_q;
  logic [1:0]  rsp_op_q;
  logic        rsp_dz_q;
  logic        rsp_to_q;

  logic is_div;
  logic cap;
  logic tmo;

  // Divide DONE is masked for the first DIV_SETTLE cycles (stale DONE)
  assign is_div = (calc_op_q == 2'b11);
  assign cap    = !is_div ||
                  ((32'(cnt_q) >= DIV_SETTLE) && bus.calc_done);

`ifdef CALC_SEQ_TIMEOUT_EN
  assign tmo = (32'(cnt_q) == TIMEOUT_CYCLES);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      calc_a_q     <= 8'd0;
      calc_b_q     <= 8'd0;
      calc_op_q    <= 2'd0;
      calc_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 16'd0;
      rsp_op_q     <= 2'd0;
      rsp_dz_q     <= 1'b0;
      rsp_to_q     <= 1'b0;
    end else begin
      calc_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            calc_a_q     <= bus.req_a;
            calc_b_q     <= bus.req_b;
            calc_op_q    <= bus.req_op;
            calc_start_q <= 1'b1;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
          if (cap) begin
            rsp_result_q <= bus.calc_result;
            rsp_dz_q     <= is_div && bus.calc_div_zero;
            rsp_op_q     <= calc_op_q;
            rsp_to_q     <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else if (tmo) begin
            rsp_result_q <= 16'hFFFF;
            rsp_dz_q     <= 1'b0;
            rsp_op_q     <= calc_op_q;
            rsp_to_q     <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.calc_a       = calc_a_q;
  assign bus.calc_b       = calc_b_q;
  assign bus.calc_op      = calc_op_q;
  assign bus.calc_start   = calc_start_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_op       = rsp_op_q;
  assign bus.rsp_div_zero = rsp_dz_q;
  assign bus.rsp_timeout  = rsp_to_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: transaction model, calculator stub,
// per-cycle compare and directed scenarios.
module tb_calc_op_sequencer;
  localparam int DS = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  calc_op_sequencer_if ifc();

  calc_op_sequencer #(
    .DIV_SETTLE     (DS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (ifc),
    .busy_o (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // transaction-level model of what the sequencer must present
  bit          m_busy = 0;
  int          m_acc  = 0;
  logic [7:0]  m_a    = 0;
  logic [7:0]  m_b    = 0;
  logic [1:0]  m_op   = 0;
  bit          m_rv   = 0;
  logic [15:0] m_res  = 0;
  logic [1:0]  m_rop  = 0;
  bit          m_dz   = 0;
  bit          m_to   = 0;

  always @(posedge clk) begin : model
    int w;
    w = cyc - (m_acc + 2);
    if (rst) begin
      m_busy = 0; m_rv = 0; m_a = 0; m_b = 0; m_op = 0;
      m_res = 0; m_rop = 0; m_dz = 0; m_to = 0;
    end else if (!m_busy) begin
      if (ifc.req_valid) begin
        m_busy = 1;
        m_acc  = cyc;
        m_a    = ifc.req_a;
        m_b    = ifc.req_b;
        m_op   = ifc.req_op;
      end
    end else if (!m_rv) begin
      if (w >= 0 && (m_op != 2'b11 || (w >= DS && ifc.calc_done))) begin
        m_rv  = 1;
        m_res = ifc.calc_result;
        m_dz  = (m_op == 2'b11) && ifc.calc_div_zero;
        m_rop = m_op;
        m_to  = 0;
      end
`ifdef CALC_SEQ_TIMEOUT_EN
      else if (w == TO) begin
        m_rv  = 1;
        m_res = 16'hFFFF;
        m_dz  = 0;
        m_rop = m_op;
        m_to  = 1;
      end
`endif
    end else if (ifc.rsp_ready) begin
      m_rv   = 0;
      m_busy = 0;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready",    ifc.req_ready, !m_busy);
      chk("busy",         busy, m_busy);
      chk("calc_start",   ifc.calc_start, m_busy && (cyc == m_acc + 1));
      chk("calc_a",       ifc.calc_a, m_a);
      chk("calc_b",       ifc.calc_b, m_b);
      chk("calc_op",      ifc.calc_op, m_op);
      chk("rsp_valid",    ifc.rsp_valid, m_rv);
      chk("rsp_result",   ifc.rsp_result, m_res);
      chk("rsp_op",       ifc.rsp_op, m_rop);
      chk("rsp_div_zero", ifc.rsp_div_zero, m_dz);
      chk("rsp_timeout",  ifc.rsp_timeout, m_to);
    end
  end

  // calculator stub: DONE pulse at a chosen WAIT count, optional stale DONE
  logic [15:0] st_res   = 0;
  int          st_k     = -100;
  bit          st_stale = 0;
  bit          st_dz    = 0;

  initial begin
    ifc.calc_done     = 1'b0;
    ifc.calc_result   = 16'd0;
    ifc.calc_div_zero = 1'b0;
    forever begin
      int w2;
      @(posedge clk);
      #1;
      w2 = cyc - (m_acc + 2);
      ifc.calc_done = (st_stale && (!m_busy || w2 < DS)) ||
                      (m_busy && !m_rv && w2 == st_k);
      ifc.calc_result   = st_res;
      ifc.calc_div_zero = st_dz;
    end
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_wait", 0, 1);
  endtask

  task automatic wait_rsp(output int rv);
    rv = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid) begin
        rv = cyc;
        break;
      end
    end
    if (rv < 0) chk("rsp_wait", 0, 1);
  endtask

  task automatic do_op(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [1:0]  op,
    input  logic [15:0] res,
    input  int          k,
    input  bit          stale,
    input  bit          dz,
    input  int          hold,
    output int          lat,
    output int          stc,
    output logic [15:0] r_res,
    output logic [1:0]  r_op,
    output logic        r_dz,
    output logic        r_to
  );
    int acc;
    int rv;
    st_res = res; st_k = k; st_stale = stale; st_dz = dz;
    ifc.rsp_ready = (hold == 0);
    ifc.req_a = a; ifc.req_b = b; ifc.req_op = op;
    ifc.req_valid = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    acc = cyc - 1;
    ifc.req_valid = 1'b0;
    stc = -1;
    rv  = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.calc_start && stc < 0) stc = cyc - acc;
      if (ifc.rsp_valid) begin
        rv = cyc;
        break;
      end
    end
    if (rv < 0) chk("rsp_wait", 0, 1);
    lat   = rv - acc;
    r_res = ifc.rsp_result;
    r_op  = ifc.rsp_op;
    r_dz  = ifc.rsp_div_zero;
    r_to  = ifc.rsp_timeout;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      ifc.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b0;
    st_stale = 0; st_k = -100; st_dz = 0;
  endtask

  int          lat;
  int          stc;
  int          rv;
  logic [15:0] r_res;
  logic [1:0]  r_op;
  logic        r_dz;
  logic        r_to;

  initial begin
    ifc.req_valid = 1'b0;
    ifc.req_a     = 8'd0;
    ifc.req_b     = 8'd0;
    ifc.req_op    = 2'd0;
    ifc.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", ifc.req_ready, 1);
    chk("rst_rsp_valid", ifc.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", ifc.calc_start, 0);
    chk("rst_result", ifc.rsp_result, 0);
    chk("rst_calc_a", ifc.calc_a, 0);

    // add, DIV_ZERO raised by stub must be dropped for non-div
    do_op(8'd200, 8'd100, 2'b00, 16'h012C, 0, 0, 1, 0,
          lat, stc, r_res, r_op, r_dz, r_to);
    chk("add_start", stc, 1);
    chk("add_lat", lat, 3);
    chk("add_res", r_res, 16'h012C);
    chk("add_op", r_op, 2'b00);
    chk("add_dz", r_dz, 0);
    @(negedge clk);
    chk("add_idle", ifc.req_ready, 1);

    // divide with stale DONE ahead of start, real DONE at count 9
    do_op(8'd100, 8'd7, 2'b11, 16'h020E, 9, 1, 0, 0,
          lat, stc, r_res, r_op, r_dz, r_to);
    chk("div_lat", lat, 12);
    chk("div_res", r_res, 16'h020E);
    chk("div_dz", r_dz, 0);

    // divide by zero, DONE at count 3
    do_op(8'd5, 8'd0, 2'b11, 16'h00FF, 3, 0, 1, 0,
          lat, stc, r_res, r_op, r_dz, r_to);
    chk("dz_lat", lat, 6);
    chk("dz_flag", r_dz, 1);
    chk("dz_op", r_op, 2'b11);

    // subtract with borrow, response held two cycles
    do_op(8'd10, 8'd20, 2'b01, 16'h01F6, 0, 0, 0, 2,
          lat, stc, r_res, r_op, r_dz, r_to);
    chk("sub_lat", lat, 3);
    chk("sub_res", r_res, 16'h01F6);
    chk("sub_op", r_op, 2'b01);

    // backpressure with a second request waiting
    st_res = 16'hFE01; st_k = -100; st_stale = 0; st_dz = 0;
    ifc.rsp_ready = 1'b0;
    ifc.req_a = 8'd255; ifc.req_b = 8'd255; ifc.req_op = 2'b10;
    ifc.req_valid = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    ifc.req_a = 8'd1; ifc.req_b = 8'd2; ifc.req_op = 2'b00;
    wait_rsp(rv);
    repeat (10) begin
      @(negedge clk);
      chk("bp_ready", ifc.req_ready, 0);
      chk("bp_valid", ifc.rsp_valid, 1);
      chk("bp_hold", ifc.rsp_result, 16'hFE01);
    end
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b0;
    st_res = 16'h0003;
    @(negedge clk);
    chk("bp_rdy_after", ifc.req_ready, 1);
    chk("bp_vld_after", ifc.rsp_valid, 0);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    @(negedge clk);
    chk("bp2_start", ifc.calc_start, 1);
    chk("bp2_a", ifc.calc_a, 8'd1);
    wait_rsp(rv);
    chk("bp2_res", ifc.rsp_result, 16'h0003);
    chk("bp2_op", ifc.rsp_op, 2'b00);
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.rsp_ready = 1'b0;

`ifdef CALC_SEQ_TIMEOUT_EN
    do_op(8'd9, 8'd3, 2'b11, 16'h0003, -100, 0, 0, 0,
          lat, stc, r_res, r_op, r_dz, r_to);
    chk("to_lat", lat, TO + 3);
    chk("to_res", r_res, 16'hFFFF);
    chk("to_flag", r_to, 1);
    chk("to_op", r_op, 2'b11);
`else
    st_k = -100;
    ifc.req_a = 8'd9; ifc.req_b = 8'd3; ifc.req_op = 2'b11;
    ifc.req_valid = 1'b1;
    wait_accept();
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    repeat (300) @(negedge clk);
    chk("nto_busy", busy, 1);
    chk("nto_valid", ifc.rsp_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", ifc.req_ready, 1);
    chk("mid_rst_valid", ifc.rsp_valid, 0);
    chk("mid_rst_res", ifc.rsp_result, 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
